// File: rtl/sva_chk_pkg.sv
// Shared limits, channel index type and population count for the window checker.
package sva_chk_pkg;
    localparam int MAX_NCH     = 32;
    localparam int MAX_DLY_LIM = 16;

    typedef logic [4:0] chan_idx_t;

    function automatic logic [5:0] popcount(input logic [MAX_NCH-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAX_NCH; i++) n += 6'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/sva_win_chan.sv
// One checker channel: ages trig through a pend vector and flags evt without cons inside the window.
module sva_win_chan #(
    parameter int MIN_DLY     = 2,
    parameter int MAX_DLY     = 3,
    parameter int FIRST_MATCH = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic trig,
    input  logic evt,
    input  logic cons,
    output logic fail
);
    // pend[d] set means an attempt started d cycles ago is still alive
    logic [MAX_DLY:1] pend;
    logic live, match, kill;

    always_comb begin
        live  = |pend[MAX_DLY:MIN_DLY];
        match = en & evt & live;
        fail  = match & ~cons;
        kill  = (FIRST_MATCH != 0) && match;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            // a trig coinciding with a match lands in pend[1], outside the kill range
            pend[1] <= trig & en;
            for (int d = 2; d <= MAX_DLY; d++)
                pend[d] <= pend[d-1] & ~(kill && (d - 1 >= MIN_DLY)) & en;
        end
    end
endmodule

// File: rtl/sva_window_checker.sv
// Multi-channel trig -> ##[MIN_DLY:MAX_DLY] evt |-> cons checker with error pulses,
// saturating violation count and first-violation capture.
module sva_window_checker
    import sva_chk_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int MIN_DLY     = 2,
    parameter int MAX_DLY     = 3,
    parameter int FIRST_MATCH = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en_i,
    input  logic [NCH-1:0]   trig_i,
    input  logic [NCH-1:0]   evt_i,
    input  logic [NCH-1:0]   cons_i,
    input  logic             clr_i,
    output logic [NCH-1:0]   err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             err_any_o,
    output chan_idx_t        first_ch_o
);
    localparam int SW = CNT_W + 6;

    if (MIN_DLY < 1 || MAX_DLY < MIN_DLY || MAX_DLY > MAX_DLY_LIM || NCH > MAX_NCH || NCH < 1)
    begin : g_bad_params
        $error("sva_window_checker: illegal NCH/MIN_DLY/MAX_DLY combination");
    end

    logic [NCH-1:0] fail;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        sva_win_chan #(
            .MIN_DLY    (MIN_DLY),
            .MAX_DLY    (MAX_DLY),
            .FIRST_MATCH(FIRST_MATCH)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en_i[i]),
            .trig (trig_i[i]),
            .evt  (evt_i[i]),
            .cons (cons_i[i]),
            .fail (fail[i])
        );
    end

    logic [5:0]       nfail;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] cnt_next;
    chan_idx_t        low_idx;

    always_comb begin
        nfail    = popcount(MAX_NCH'(fail));
        sum      = SW'(err_cnt_o) + SW'(nfail);
        // any carry above CNT_W bits means the counter would wrap; pin it at all-ones
        cnt_next = (sum[SW-1:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];
        low_idx  = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (fail[i]) low_idx = chan_idx_t'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_o      <= '0;
            err_cnt_o  <= '0;
            err_any_o  <= 1'b0;
            first_ch_o <= '0;
        end else begin
            err_o <= fail;
            if (clr_i) begin
                err_cnt_o  <= '0;
                err_any_o  <= 1'b0;
                first_ch_o <= '0;
            end else begin
                err_cnt_o <= cnt_next;
                if (|fail) begin
                    err_any_o <= 1'b1;
                    if (!err_any_o) first_ch_o <= low_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_sva_window_checker.sv
// Random + directed check of two checker instances (all-match and first-match) against a queue-based model.
module tb_sva_window_checker;
    localparam int NCH = 4, MIN_D = 2, MAX_D = 3, CW = 4, CMAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NCH-1:0] en = '1, trig = '0, evt = '0, cons = '0;
    logic clr = 1'b0;

    logic [NCH-1:0] err0, err1;
    logic [CW-1:0]  cnt0, cnt1;
    logic           any0, any1;
    logic [4:0]     first0, first1;

    always #5 clk = ~clk;

    sva_window_checker #(.NCH(NCH), .MIN_DLY(MIN_D), .MAX_DLY(MAX_D), .FIRST_MATCH(0), .CNT_W(CW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .trig_i(trig), .evt_i(evt), .cons_i(cons), .clr_i(clr),
        .err_o(err0), .err_cnt_o(cnt0), .err_any_o(any0), .first_ch_o(first0));

    sva_window_checker #(.NCH(NCH), .MIN_DLY(MIN_D), .MAX_DLY(MAX_D), .FIRST_MATCH(1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .trig_i(trig), .evt_i(evt), .cons_i(cons), .clr_i(clr),
        .err_o(err1), .err_cnt_o(cnt1), .err_any_o(any1), .first_ch_o(first1));

    int total = 0, bad = 0;
    int cyc = 0;

    // model: each live attempt is just the cycle its trig was seen
    int att[2][NCH][$];
    logic [NCH-1:0] e_err[2];
    int e_cnt[2], e_first[2];
    bit e_any[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        for (int f = 0; f < 2; f++) begin
            logic [NCH-1:0] fl;
            fl = '0;
            for (int i = 0; i < NCH; i++) begin
                int nq[$];
                int a;
                bit live, m;
                nq = {};
                live = 0;
                m = 0;
                if (rst_n && en[i]) begin
                    for (int k = 0; k < att[f][i].size(); k++) begin
                        a = cyc - att[f][i][k];
                        if (a >= MIN_D && a <= MAX_D) live = 1;
                    end
                    m = evt[i] && live;
                    fl[i] = m && !cons[i];
                    for (int k = 0; k < att[f][i].size(); k++) begin
                        a = cyc - att[f][i][k];
                        if (a < MAX_D && !(f == 1 && m && a >= MIN_D)) nq.push_back(att[f][i][k]);
                    end
                    if (trig[i]) nq.push_back(cyc);
                end
                att[f][i] = nq;
            end
            if (!rst_n) begin
                e_err[f] = '0; e_cnt[f] = 0; e_any[f] = 0; e_first[f] = 0;
            end else begin
                e_err[f] = fl;
                if (clr) begin
                    e_cnt[f] = 0; e_any[f] = 0; e_first[f] = 0;
                end else begin
                    e_cnt[f] = e_cnt[f] + $countones(fl);
                    if (e_cnt[f] > CMAX) e_cnt[f] = CMAX;
                    if (fl != 0) begin
                        if (!e_any[f]) begin
                            for (int j = NCH - 1; j >= 0; j--) if (fl[j]) e_first[f] = j;
                        end
                        e_any[f] = 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("err_fm0",   32'(err0),   32'(e_err[0]));
        chk("cnt_fm0",   32'(cnt0),   32'(e_cnt[0]));
        chk("any_fm0",   32'(any0),   32'(e_any[0]));
        chk("first_fm0", 32'(first0), 32'(e_first[0]));
        chk("err_fm1",   32'(err1),   32'(e_err[1]));
        chk("cnt_fm1",   32'(cnt1),   32'(e_cnt[1]));
        chk("any_fm1",   32'(any1),   32'(e_any[1]));
        chk("first_fm1", 32'(first1), 32'(e_first[1]));
    endtask

    task automatic tick(input logic [NCH-1:0] t, input logic [NCH-1:0] ev, input logic [NCH-1:0] co);
        trig = t; evt = ev; cons = co;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        tick('0, '0, '0);
        tick('0, '0, '0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_err", 32'(err0), 0);
        rst_n = 1'b1;

        // pass inside window
        tick(4'b0001, '0, '0); tick('0, '0, '0); tick('0, 4'b0001, 4'b0001); tick('0, '0, '0);
        chk("t1_cnt", 32'(cnt0), 0);
        // fail at window end
        tick(4'b0010, '0, '0); tick('0, '0, '0); tick('0, '0, '0); tick('0, 4'b0010, '0);
        chk("t2_err", 32'(err0), 32'h2);
        tick('0, '0, '0);
        chk("t2_cnt", 32'(cnt0), 1);
        chk("t2_first", 32'(first0), 1);
        // second evt in window: only the all-match instance fails
        tick(4'b0100, '0, '0); tick('0, '0, '0); tick('0, 4'b0100, 4'b0100); tick('0, 4'b0100, '0);
        chk("t3_err_fm0", 32'(err0), 32'h4);
        chk("t3_err_fm1", 32'(err1), 0);
        tick('0, '0, '0); tick('0, '0, '0);
        chk("t3_cnt_fm0", 32'(cnt0), 2);
        chk("t3_cnt_fm1", 32'(cnt1), 1);
        // evt outside window
        tick(4'b0001, '0, '0); tick('0, 4'b0001, '0); tick('0, '0, '0); tick('0, '0, '0); tick('0, 4'b0001, '0);
        tick('0, '0, '0);
        chk("t4_cnt", 32'(cnt0), 2);
        // steady violations saturate the counter
        for (int k = 0; k < 20; k++) tick(4'b0001, 4'b0001, '0);
        chk("t4_sat", 32'(cnt0), CMAX);
        chk("t4_err", 32'(err0), 32'h1);
        tick('0, '0, '0); tick('0, '0, '0); tick('0, '0, '0);
        // simultaneous fails, then clear colliding with a fail
        clr = 1'b1; tick('0, '0, '0); clr = 1'b0;
        tick(4'b1001, '0, '0); tick('0, '0, '0); tick('0, 4'b1001, '0);
        chk("t5_cnt", 32'(cnt0), 2);
        chk("t5_first", 32'(first0), 0);
        tick(4'b1001, '0, '0); tick('0, '0, '0);
        clr = 1'b1; tick('0, 4'b1001, '0); clr = 1'b0;
        chk("t5_clr_cnt", 32'(cnt0), 0);
        chk("t5_clr_any", 32'(any0), 0);
        chk("t5_clr_err", 32'(err0), 32'h9);
        tick('0, '0, '0); tick('0, '0, '0);
        // disable kills pending, reset discards in-flight
        tick(4'b0001, '0, '0);
        en = 4'b1110; tick('0, '0, '0); en = 4'b1111;
        tick('0, 4'b0001, '0); tick('0, 4'b0001, '0);
        chk("t6_en_err", 32'(err0), 0);
        tick(4'b0001, '0, '0);
        rst_n = 1'b0; tick('0, '0, '0); rst_n = 1'b1;
        tick('0, 4'b0001, '0); tick('0, 4'b0001, '0);
        chk("t6_rst_err", 32'(err0), 0);
        chk("t6_rst_cnt", 32'(cnt0), 0);

        for (int k = 0; k < 600; k++) begin
            en    = ($urandom_range(0, 12) == 0) ? 4'($urandom) : 4'hF;
            trig  = 4'($urandom) & 4'($urandom);
            evt   = 4'($urandom);
            cons  = 4'($urandom);
            clr   = ($urandom_range(0, 40) == 0);
            rst_n = !($urandom_range(0, 150) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
